// File: rtl/fut_key_gen.sv
// fut_key_gen: round-key generator for the downstream key-select stage.
//
// A 128-bit master key is held as M0/M1 and copied into the working
// registers W0/W1 when a sequence starts. The sequence then hands out
// eleven 64-bit round keys, indices 0..10, through a valid/ack handshake.
//
// Ports:
//   clk       rising-edge clock for all state
//   rst       asynchronous active-low reset
//   key_in    master key, K0 = key_in[127:64], K1 = key_in[63:0]
//   key_ld    load key_in into master and working registers (IDLE only)
//   start     begin a round-key sequence (IDLE only)
//   abort     cancel a running sequence, back to IDLE, no done pulse
//   rk_ack    downstream accepts the current round key
//   rk_out    current round key
//   rk_valid  rk_out / rnd_idx are valid
//   rnd_idx   index of the current round key, 0..10
//   busy      sequence running
//   done      one-cycle pulse after round key 10 is accepted
module fut_key_gen (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_ld,
    input  logic         start,
    input  logic         abort,
    input  logic         rk_ack,
    output logic [63:0]  rk_out,
    output logic         rk_valid,
    output logic [3:0]   rnd_idx,
    output logic         busy,
    output logic         done
);

    // state | meaning
    // IDLE  | waiting for key_ld / start
    // RUN   | handing out round keys 0..10
    // DONE  | last key accepted, done pulse visible for one cycle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd10;

    state_t      state_q;
    logic [63:0] m0_q;
    logic [63:0] m1_q;
    logic [63:0] w0_q;
    logic [63:0] w1_q;
    logic [3:0]  idx_q;
    logic        valid_q;
    logic        done_q;

    logic        xfer;

    assign xfer = valid_q && rk_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            m0_q    <= '0;
            m1_q    <= '0;
            w0_q    <= '0;
            w1_q    <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (key_ld) begin
                        m0_q <= key_in[127:64];
                        m1_q <= key_in[63:0];
                        w0_q <= key_in[127:64];
                        w1_q <= key_in[63:0];
                    end
                    if (start) begin
                        // A simultaneous load wins over the stored master key.
                        w0_q    <= key_ld ? key_in[127:64] : m0_q;
                        w1_q    <= key_ld ? key_in[63:0]   : m1_q;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        valid_q <= 1'b0;
                        idx_q   <= '0;
                        state_q <= IDLE;
                    end else if (xfer) begin
                        // Working key advances only after the odd (W1) half is used.
                        if (idx_q[0]) begin
                            w0_q <= {w0_q[58:0], w0_q[63:59]};
                            w1_q <= {w1_q[58:0], w1_q[63:59]};
                        end
                        if (idx_q == LAST_IDX) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rk_out   = (idx_q[0] ? w1_q : w0_q) ^ {60'b0, idx_q};
    assign rk_valid = valid_q;
    assign rnd_idx  = idx_q;
    assign busy     = (state_q == RUN);
    assign done     = done_q;

endmodule
